eth_tx_speed_switch_ctrl: RTL and testbench

Sequencer for the RGMII TX clocking path on the 250 MHz clock. It accepts link-speed change requests (1000M/100M/10M) from the CSR side and waits for the TX MAC to go idle. It then holds the TX clock generator and TX datapath in reset while it changes the TX clock divider setting, and releases them in a fixed order so the PHY TX clock and GTX clock restart phase-aligned. It sits between the Ethernet CSR block and the GTX/PHY TX clock generator.

---
 rtl/eth_pkg.sv | 30 +++
 rtl/bsg_counter_clear_up.sv | 24 ++
 rtl/eth_tx_speed_switch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_eth_tx_speed_switch_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX clocking types: link speed encodings and speed-switch FSM states.
// Optional feature macro used by the sequencer: ETH_SPEED_SWITCH_TIMEOUT_EN.
package eth_pkg;

  typedef enum logic [1:0] {
    e_eth_speed_1000m = 2'd0,
    e_eth_speed_100m  = 2'd1,
    e_eth_speed_10m   = 2'd2,
    e_eth_speed_rsvd  = 2'd3
  } eth_speed_e;

  typedef enum logic [2:0] {
    e_sw_reset  = 3'd0,
    e_sw_settle = 3'd1,
    e_sw_idle   = 3'd2,
    e_sw_drain  = 3'd3,
    e_sw_done   = 3'd4
  } eth_sw_state_e;

  function automatic int bsg_safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up in the same cycle yields init+1.
module bsg_counter_clear_up #(
  parameter int width_p = 8,
  parameter logic [width_p-1:0] init_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;
  logic [width_p-1:0] w_base;

  assign w_base  = clear_i ? init_val_p : r_count;
  assign count_o = r_count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_count <= init_val_p;
    else         r_count <= w_base + {{(width_p-1){1'b0}}, up_i};
  end

endmodule

// File: rtl/eth_tx_speed_switch_ctrl.sv
// RGMII TX speed-switch sequencer: drains TX, resets clock gens, reprograms divider.
// Define ETH_SPEED_SWITCH_TIMEOUT_EN to bound the TX drain wait with drain_timeout_p.
module eth_tx_speed_switch_ctrl
  import eth_pkg::*;
#(
  parameter int drain_timeout_p    = 1024,
  parameter int gen_reset_cycles_p = 4,
  parameter int settle_cycles_p    = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       speed_v_i,
  input  logic [1:0] speed_i,
  output logic       speed_ready_o,
  input  logic       tx_idle_i,
  output logic [1:0] clk_setting_o,
  output logic       clk_gen_reset_o,
  output logic       tx_reset_o,
  output logic [1:0] speed_o,
  output logic       done_o,
  output logic       err_o,
  output logic       timeout_o
);

  localparam int max_lp = max3(drain_timeout_p,
                               gen_reset_cycles_p,
                               settle_cycles_p);
  localparam int cnt_w_lp = bsg_safe_clog2(max_lp) + 1;

  localparam logic [cnt_w_lp-1:0] gen_term_lp =
    cnt_w_lp'(gen_reset_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] settle_term_lp =
    cnt_w_lp'(settle_cycles_p - 1);
`ifdef ETH_SPEED_SWITCH_TIMEOUT_EN
  localparam logic [cnt_w_lp-1:0] drain_term_lp =
    cnt_w_lp'(drain_timeout_p - 1);
`endif

  eth_sw_state_e r_state, w_state_n;
  eth_speed_e    r_speed_lat, w_lat_n;
  eth_speed_e    r_clk_setting, w_setting_n;
  eth_speed_e    r_speed, w_speed_n;
  eth_speed_e    w_req;

  logic r_gen_reset, w_gen_reset_n;
  logic r_tx_reset, w_tx_reset_n;
  logic r_ready, w_ready_n;
  logic r_done, w_done_n;
  logic r_err, w_err_n;
  logic r_timeout, w_timeout_n;

  logic                w_accept;
  logic                w_up;
  logic                w_clear;
  logic [cnt_w_lp-1:0] w_cnt;

  assign w_req    = eth_speed_e'(speed_i);
  assign w_accept = speed_v_i & r_ready & (r_state == e_sw_idle);

  bsg_counter_clear_up #(
    .width_p   (cnt_w_lp),
    .init_val_p('0)
  ) u_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(w_clear),
    .up_i   (w_up & ~w_clear),
    .count_o(w_cnt)
  );

  always_comb begin
    w_state_n   = r_state;
    w_lat_n     = r_speed_lat;
    w_setting_n = r_clk_setting;
    w_speed_n   = r_speed;
    w_done_n    = 1'b0;
    w_err_n     = 1'b0;
    w_timeout_n = r_timeout;
    w_up        = 1'b0;

    unique case (r_state)
      e_sw_reset: begin
        w_up = 1'b1;
        if (w_cnt == gen_term_lp) w_state_n = e_sw_settle;
      end
      e_sw_settle: begin
        w_up = 1'b1;
        if (w_cnt == settle_term_lp) w_state_n = e_sw_done;
      end
      e_sw_done: w_state_n = e_sw_idle;
      e_sw_idle: begin
        if (w_accept) begin
          unique case (1'b1)
            (w_req == e_eth_speed_rsvd): w_err_n  = 1'b1;
            (w_req == r_speed):          w_done_n = 1'b1;
            default: begin
              w_lat_n   = w_req;
              w_state_n = e_sw_drain;
            end
          endcase
        end
      end
      e_sw_drain: begin
        if (tx_idle_i) begin
          w_state_n   = e_sw_reset;
          w_setting_n = r_speed_lat;
          w_speed_n   = r_speed_lat;
        end
`ifdef ETH_SPEED_SWITCH_TIMEOUT_EN
        else if (w_cnt == drain_term_lp) begin
          w_state_n   = e_sw_reset;
          w_setting_n = r_speed_lat;
          w_speed_n   = r_speed_lat;
          w_timeout_n = 1'b1;
        end else begin
          w_up = 1'b1;
        end
`endif
      end
      default: w_state_n = e_sw_reset;
    endcase

    w_clear       = (w_state_n != r_state);
    w_done_n      = w_done_n | (w_state_n == e_sw_done);
    w_gen_reset_n = (w_state_n == e_sw_reset);
    w_tx_reset_n  = (w_state_n == e_sw_reset) |
                    (w_state_n == e_sw_settle);
    w_ready_n     = (w_state_n == e_sw_idle);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= e_sw_reset;
      r_speed_lat   <= e_eth_speed_1000m;
      r_clk_setting <= e_eth_speed_1000m;
      r_speed       <= e_eth_speed_1000m;
      r_gen_reset   <= 1'b1;
      r_tx_reset    <= 1'b1;
      r_ready       <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_speed_lat   <= w_lat_n;
      r_clk_setting <= w_setting_n;
      r_speed       <= w_speed_n;
      r_gen_reset   <= w_gen_reset_n;
      r_tx_reset    <= w_tx_reset_n;
      r_ready       <= w_ready_n;
      r_done        <= w_done_n;
      r_err         <= w_err_n;
      r_timeout     <= w_timeout_n;
    end
  end

  assign speed_ready_o   = r_ready;
  assign clk_setting_o   = r_clk_setting;
  assign clk_gen_reset_o = r_gen_reset;
  assign tx_reset_o      = r_tx_reset;
  assign speed_o         = r_speed;
  assign done_o          = r_done;
  assign err_o           = r_err;
`ifdef ETH_SPEED_SWITCH_TIMEOUT_EN
  assign timeout_o       = r_timeout;
`else
  assign timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_speed_switch_ctrl.sv
// Bench for eth_tx_speed_switch_ctrl: pulse scoreboard plus per-scenario level checks.
module tb_eth_tx_speed_switch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v = 1'b0;
  logic [1:0] spd = 2'b00;
  logic       idle = 1'b1;
  logic       ready, gen_rst, tx_rst, done, err, tmo;
  logic [1:0] setting, speed;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    int         at;
    logic [1:0] spd;
  } exp_t;
  exp_t q[$];

  eth_tx_speed_switch_ctrl #(
    .drain_timeout_p   (8),
    .gen_reset_cycles_p(4),
    .settle_cycles_p   (16)
  ) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .speed_v_i      (v),
    .speed_i        (spd),
    .speed_ready_o  (ready),
    .tx_idle_i      (idle),
    .clk_setting_o  (setting),
    .clk_gen_reset_o(gen_rst),
    .tx_reset_o     (tx_rst),
    .speed_o        (speed),
    .done_o         (done),
    .err_o          (err),
    .timeout_o      (tmo)
  );

  always #2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse done=%b err=%b cyc=%0d",
                 done, err, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({done, err} !== {~e.is_err, e.is_err} ||
            cyc !== e.at || speed !== e.spd) begin
          errors++;
          $display("FAIL pulse got done=%b err=%b cyc=%0d spd=%b exp err=%0d cyc=%0d spd=%b",
                   done, err, cyc, speed, e.is_err, e.at, e.spd);
        end
      end
    end
  end

  task automatic push_exp(input bit is_err, input int at,
                          input logic [1:0] s);
    exp_t e;
    e.is_err = is_err;
    e.at = at;
    e.spd = s;
    q.push_back(e);
  endtask

  task automatic send_req(input logic [1:0] s, input bit do_push,
                          input bit is_err, input int lat,
                          input logic [1:0] espd, output int n);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req got=%b exp=1", ready);
    end
    v = 1'b1;
    spd = s;
    @(posedge clk);
    #1;
    n = cyc;
    if (do_push) push_exp(is_err, n + lat, espd);
    @(negedge clk);
    v = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL wait_pulse timeout pending=%0d exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic do_bringup();
    int r, g, t;
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
    push_exp(1'b0, r + 20, 2'b00);
    g = 0;
    t = 0;
    for (int k = 0; k < 24; k++) begin
      if (gen_rst) g++;
      if (tx_rst) t++;
      @(negedge clk);
    end
    checks++;
    if (g !== 4 || t !== 20) begin
      errors++;
      $display("FAIL bringup_len gen=%0d tx=%0d exp 4 20", g, t);
    end
    checks++;
    if (speed !== 2'b00 || setting !== 2'b00 || ready !== 1'b1) begin
      errors++;
      $display("FAIL bringup_state spd=%b set=%b rdy=%b exp 00 00 1",
               speed, setting, ready);
    end
    wait_empty(10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gen_rst, tx_rst, ready, done, err, tmo, setting, speed}
        !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL reset_vals got=%b exp=1100000000",
               {gen_rst, tx_rst, ready, done, err, tmo, setting, speed});
    end
    do_bringup();
  endtask

  task automatic test_switch();
    int n;
    idle = 1'b1;
    send_req(2'b01, 1'b1, 1'b0, 21, 2'b01, n);
    checks++;
    if (gen_rst !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL switch_drain gen=%b rdy=%b exp 0 0", gen_rst, ready);
    end
    @(negedge clk);
    checks++;
    if (setting !== 2'b01 || gen_rst !== 1'b1 || tx_rst !== 1'b1) begin
      errors++;
      $display("FAIL switch_start set=%b gen=%b tx=%b exp 01 1 1",
               setting, gen_rst, tx_rst);
    end
    wait_empty(40);
  endtask

  task automatic test_reserved_and_same();
    int n, bad;
    send_req(2'b11, 1'b1, 1'b1, 0, 2'b01, n);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (gen_rst || tx_rst) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0 || speed !== 2'b01) begin
      errors++;
      $display("FAIL reserved bad=%0d spd=%b exp 0 01", bad, speed);
    end
    wait_empty(5);
    send_req(2'b01, 1'b1, 1'b0, 0, 2'b01, n);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (gen_rst || tx_rst || !ready) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL same_speed bad=%0d exp=0", bad);
    end
    wait_empty(5);
  endtask

`ifdef ETH_SPEED_SWITCH_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    idle = 1'b0;
    send_req(2'b10, 1'b1, 1'b0, 28, 2'b10, n);
    while (cyc < n + 7) @(negedge clk);
    checks++;
    if (gen_rst !== 1'b0 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early gen=%b tmo=%b exp 0 0", gen_rst, tmo);
    end
    @(negedge clk);
    checks++;
    if (gen_rst !== 1'b1 || tmo !== 1'b1 || setting !== 2'b10) begin
      errors++;
      $display("FAIL tmo_fire gen=%b tmo=%b set=%b exp 1 1 10",
               gen_rst, tmo, setting);
    end
    wait_empty(40);
    checks++;
    if (tmo !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky got=%b exp=1", tmo);
    end
    idle = 1'b1;
  endtask
`else
  task automatic test_drain();
    int n, e, bad;
    idle = 1'b0;
    send_req(2'b10, 1'b0, 1'b0, 0, 2'b10, n);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (gen_rst || tx_rst || tmo) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL drain_wait bad=%0d exp=0", bad);
    end
    idle = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    push_exp(1'b0, e + 20, 2'b10);
    @(negedge clk);
    checks++;
    if (gen_rst !== 1'b1 || setting !== 2'b10) begin
      errors++;
      $display("FAIL drain_start gen=%b set=%b exp 1 10", gen_rst, setting);
    end
    wait_empty(40);
  endtask
`endif

  task automatic test_back_to_back();
    int n;
    send_req(2'b00, 1'b1, 1'b0, 21, 2'b00, n);
    while (cyc < n + 5) @(negedge clk);
    v = 1'b1;
    spd = 2'b10;
    @(negedge clk);
    v = 1'b0;
    wait_empty(40);
    send_req(2'b01, 1'b1, 1'b0, 21, 2'b01, n);
    wait_empty(40);
    checks++;
    if (speed !== 2'b01 || setting !== 2'b01) begin
      errors++;
      $display("FAIL b2b_final spd=%b set=%b exp 01 01", speed, setting);
    end
  endtask

  task automatic test_reset_mid_settle();
    int n;
    idle = 1'b1;
    send_req(2'b10, 1'b0, 1'b0, 0, 2'b10, n);
    while (cyc < n + 10) @(negedge clk);
    checks++;
    if (gen_rst !== 1'b0 || tx_rst !== 1'b1 || setting !== 2'b10) begin
      errors++;
      $display("FAIL settle_lvl gen=%b tx=%b set=%b exp 0 1 10",
               gen_rst, tx_rst, setting);
    end
    #1;
    rst = 1'b1;
    q.delete();
    #0.5;
    checks++;
    if ({gen_rst, tx_rst, ready, done, err, tmo, setting, speed}
        !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL async_reset got=%b exp=1100000000",
               {gen_rst, tx_rst, ready, done, err, tmo, setting, speed});
    end
    repeat (2) @(negedge clk);
    do_bringup();
    checks++;
    if (setting !== 2'b00 || speed !== 2'b00) begin
      errors++;
      $display("FAIL post_abort set=%b spd=%b exp 00 00", setting, speed);
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_reserved_and_same();
`ifdef ETH_SPEED_SWITCH_TIMEOUT_EN
    test_timeout();
`else
    test_drain();
`endif
    test_back_to_back();
    test_reset_mid_settle();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
